// File: rtl/regfile_mp.sv
// Multi-port integer register file: two prioritised write ports, NRD registered read ports
// with write-to-read bypass, and a post-reset clear sequencer. Register 0 is hardwired to zero.
module regfile_mp #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic [AW-1:0]       dbg_sel,
    output logic [XLEN-1:0]     dbg_data,
    output logic                wr_drop
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e              state_q;
    logic [AW-1:0]       ptr_q;
    logic                ready_q;
    logic                wr_drop_q;
    logic [NRD*XLEN-1:0] rdata_q;
    logic [NRD*XLEN-1:0] rdata_d;
    logic [XLEN-1:0]     mem_q [NREG];
    logic                wen0;
    logic                wen1;

    assign wen0 = we0 && (waddr0 != '0);
    assign wen1 = we1 && (waddr1 != '0);

    // Read data reflects the array as it will be after this edge: port 1 bypass beats port 0.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NRD; k++) begin
            if (raddr[k*AW +: AW] == '0) begin
                rdata_d[k*XLEN +: XLEN] = '0;
            end else if (wen1 && (waddr1 == raddr[k*AW +: AW])) begin
                rdata_d[k*XLEN +: XLEN] = wdata1;
            end else if (wen0 && (waddr0 == raddr[k*AW +: AW])) begin
                rdata_d[k*XLEN +: XLEN] = wdata0;
            end else begin
                rdata_d[k*XLEN +: XLEN] = mem_q[raddr[k*AW +: AW]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            ptr_q     <= AW'(1);
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_q + AW'(1);
                    rdata_q      <= '0;
                    if (we0 || we1) begin
                        wr_drop_q <= 1'b1;
                    end
                    if (ptr_q == AW'(NREG - 1)) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    // Port 1 assigned last so it wins on an address collision.
                    if (wen0) begin
                        mem_q[waddr0] <= wdata0;
                    end
                    if (wen1) begin
                        mem_q[waddr1] <= wdata1;
                    end
                    rdata_q <= rdata_d;
                end
            endcase
        end
    end

    always_comb begin
        dbg_data = '0;
        if ((state_q == StRun) && (dbg_sel != '0)) begin
            dbg_data = mem_q[dbg_sel];
        end
    end

    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

    localparam int unsigned XLEN = 64;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    localparam int SigReady = 0;
    localparam int SigRd0   = 1;
    localparam int SigRd1   = 2;
    localparam int SigDbg   = 3;
    localparam int SigDrop  = 4;

    typedef struct {
        int          cyc;
        int          sig;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                ready;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [AW-1:0]       dbg_sel;
    logic [XLEN-1:0]     dbg_data;
    logic                wr_drop;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .raddr    (raddr),
        .rdata    (rdata),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            SigReady: observe = {63'd0, ready};
            SigRd0:   observe = rdata[0 +: XLEN];
            SigRd1:   observe = rdata[XLEN +: XLEN];
            SigDbg:   observe = dbg_data;
            default:  observe = {63'd0, wr_drop};
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t e;
            logic [63:0] act;
            e = sb_q.pop_front();
            act = observe(e.sig);
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: cycle %0d got %h want %h", e.name, cyc, act, e.exp);
            end
        end
    end

    // Offset 0: observed after the edge just taken; offset 1: after the next edge.
    task automatic expect_at(input int off, input int sig, input logic [63:0] exp,
                             input string name);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_writes();
        expect_at(1, SigReady, 64'd0, "rst_ready");
        expect_at(1, SigRd0,   64'd0, "rst_rdata0");
        expect_at(1, SigRd1,   64'd0, "rst_rdata1");
        expect_at(1, SigDrop,  64'd0, "rst_wr_drop");
        step();
        dbg_sel = 5'd7;
        expect_at(0, SigDbg, 64'd0, "rst_dbg");
        rst = 1'b0;
    endtask

    // 31 clean edges; optionally a dropped write on port 1 at the 5th one.
    task automatic do_clear(input bit drop_at5);
        for (int i = 1; i <= 31; i++) begin
            if (drop_at5 && i == 5) begin
                we1 = 1'b1; waddr1 = 5'd3; wdata1 = 64'h33;
            end else begin
                idle_writes();
            end
            expect_at(1, SigReady, (i == 31) ? 64'd1 : 64'd0, "clear_ready");
            expect_at(1, SigRd0, 64'd0, "clear_rdata0");
            if (drop_at5 && i >= 5) expect_at(1, SigDrop, 64'd1, "clear_wr_drop");
            step();
            dbg_sel = AW'(i);
            expect_at(0, SigDbg, 64'd0, "clear_dbg");
        end
        idle_writes();
    endtask

    initial begin
        rst = 1'b1;
        idle_writes();
        raddr   = '0;
        dbg_sel = '0;

        // Reset then idle
        do_reset();
        set_raddr(5'd9, 5'd3);
        do_clear(1'b0);
        expect_at(0, SigDrop, 64'd0, "idle_wr_drop");

        // Basic write then read
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hDEAD_BEEF_0000_0005;
        step();
        idle_writes();
        dbg_sel = 5'd5;
        expect_at(0, SigDbg, 64'hDEAD_BEEF_0000_0005, "basic_dbg");
        set_raddr(5'd5, 5'd1);
        expect_at(1, SigRd0, 64'hDEAD_BEEF_0000_0005, "basic_rdata0");
        expect_at(1, SigRd1, 64'd0, "cleared_r1");
        step();

        // Dual write to one address with bypass read on port 1
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 64'h22;
        set_raddr(5'd5, 5'd7);
        expect_at(1, SigRd1, 64'h22, "prio_bypass_rdata1");
        expect_at(1, SigRd0, 64'hDEAD_BEEF_0000_0005, "prio_rdata0");
        step();
        idle_writes();
        dbg_sel = 5'd7;
        expect_at(0, SigDbg, 64'h22, "prio_dbg");

        // Independent writes, port 0 bypass and port 1 bypass on distinct registers
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 64'h1212;
        we1 = 1'b1; waddr1 = 5'd13; wdata1 = 64'h1313;
        set_raddr(5'd12, 5'd13);
        expect_at(1, SigRd0, 64'h1212, "bypass0_rdata0");
        expect_at(1, SigRd1, 64'h1313, "bypass1_rdata1");
        step();
        idle_writes();
        set_raddr(5'd13, 5'd12);
        expect_at(1, SigRd0, 64'h1313, "stored13_rdata0");
        expect_at(1, SigRd1, 64'h1212, "stored12_rdata1");
        step();

        // Register 0 protection
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = '1;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = '1;
        set_raddr(5'd0, 5'd0);
        expect_at(1, SigRd0, 64'd0, "x0_rdata0");
        expect_at(1, SigRd1, 64'd0, "x0_rdata1");
        step();
        idle_writes();
        dbg_sel = 5'd0;
        expect_at(0, SigDbg, 64'd0, "x0_dbg");

        // Reset mid-operation
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 64'h99;
        set_raddr(5'd9, 5'd9);
        expect_at(1, SigRd0, 64'h99, "r9_before_reset");
        step();
        idle_writes();
        dbg_sel = 5'd9;
        expect_at(0, SigDbg, 64'h99, "r9_dbg_before_reset");
        do_reset();
        do_clear(1'b0);
        set_raddr(5'd9, 5'd7);
        expect_at(1, SigRd0, 64'd0, "r9_after_reset");
        expect_at(1, SigRd1, 64'd0, "r7_after_reset");
        expect_at(1, SigDrop, 64'd0, "reset_wr_drop");
        step();

        // Write during clear is dropped and flagged
        do_reset();
        set_raddr(5'd3, 5'd3);
        do_clear(1'b1);
        expect_at(1, SigRd0, 64'd0, "drop_r3_rdata0");
        expect_at(1, SigDrop, 64'd1, "drop_sticky");
        step();
        dbg_sel = 5'd3;
        expect_at(0, SigDbg, 64'd0, "drop_r3_dbg");
        step();

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) step();
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
